// File: rtl/ll_walker.sv
// ll_walker: linked-list pointer walker with a writable next-pointer table.
// Accepts list head pointers on a valid/ready port and streams every node of
// each list, one per beat, with a last-node marker and gapless chaining of
// back-to-back lists. Node 0 is the terminator and is never emitted.
//
// Optional feature: define LL_HOP_LIMIT_EN to bound every list to MAX_HOPS
// nodes. A list cut short by the limit gets out_last forced on its final beat
// and raises the sticky err_loop flag. Without the macro, err_loop is tied to 0.
module ll_walker #(
    parameter int N        = 256,
    parameter int W_PTR    = $clog2(N),
    parameter int MAX_HOPS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [W_PTR-1:0] wr_addr,
    input  logic [W_PTR-1:0] wr_next,
    input  logic [W_PTR-1:0] start,
    input  logic             start_vld,
    output logic             start_rdy,
    output logic [W_PTR-1:0] out_ptr,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             out_last,
    output logic             err_loop
);

    // Next-pointer table: one W_PTR entry per node, entry 0 pinned to 0.
    logic [W_PTR-1:0] next_q [N];
    logic [W_PTR-1:0] next_d [N];

    // Output register.
    logic [W_PTR-1:0] out_ptr_q, out_ptr_d;
    logic             out_vld_q, out_vld_d;
    logic             out_last_q, out_last_d;

    // Walk control.
    logic             adv;         // output register may load this cycle
    logic             walk_done;   // current beat ends its list early (hop limit)
    logic [W_PTR-1:0] nxt;         // successor of the beat being held
    logic             take_start;  // a new list head is accepted this cycle
    logic [W_PTR-1:0] cur;         // pointer loaded into the output register
    logic [W_PTR-1:0] cur_next;    // table entry of cur, sampled at load time
    logic [W_PTR-1:0] held_next;   // table entry of the beat being held

    // Table reads are combinational; out-of-range pointers read as terminator.
    assign held_next = (int'(out_ptr_q) < N) ? next_q[out_ptr_q] : '0;
    assign cur_next  = (int'(cur) < N) ? next_q[cur] : '0;

    assign adv        = !out_vld_q || out_rdy;
    assign nxt        = (out_vld_q && !walk_done) ? held_next : '0;
    assign start_rdy  = adv && (nxt == '0);
    assign take_start = start_rdy && start_vld;
    assign cur        = take_start ? start : nxt;

    // Table write: entry 0 stays 0; the read path sees the old value until the edge.
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
        next_d = next_q;
        if (wr_en && wr_addr != '0 && int'(wr_addr) < N) begin
            next_d[wr_addr] = wr_next;
        end
    end

    // Table storage; reset empties every list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is flop-based, so it can be (and must be) cleared by reset; a RAM could not.
            for (int i = 0; i < N; i++) begin
                next_q[i] <= '0;
            end
        end else begin
            next_q <= next_d;
        end
    end

`ifdef LL_HOP_LIMIT_EN
    localparam int W_HOP = $clog2(MAX_HOPS + 1);

    logic [W_HOP-1:0] hop_q, hop_d;
    logic             term_q, term_d;
    logic             err_q, err_d;
    logic             hop_cut;

    assign walk_done = term_q;
    assign err_loop  = err_q;

    // Hop counting: 1 on a head load, saturating +1 on each follow-on load.
    always_comb begin
        hop_d   = hop_q;
        term_d  = term_q;
        err_d   = err_q;
        hop_cut = 1'b0;
        if (adv) begin
            term_d = 1'b0;
            if (cur != '0) begin
                if (take_start) begin
                    hop_d = W_HOP'(1);
                end else if (hop_q != {W_HOP{1'b1}}) begin
                    hop_d = hop_q + W_HOP'(1);
                end
                if (hop_d == W_HOP'(MAX_HOPS) && cur_next != '0) begin
                    hop_cut = 1'b1;
                    term_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
        end
    end

    // Hop counter, early-termination marker and sticky loop error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hop_q  <= '0;
            term_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hop_q  <= hop_d;
            term_q <= term_d;
            err_q  <= err_d;
        end
    end
`else
    logic hop_cut;

    assign hop_cut   = 1'b0;
    assign walk_done = 1'b0;
    assign err_loop  = 1'b0;
`endif

    // Output register next state: load on adv, hold while stalled.
    always_comb begin
        out_ptr_d  = out_ptr_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        if (adv) begin
            out_ptr_d  = cur;
            out_vld_d  = (cur != '0);
            out_last_d = (cur != '0) && ((cur_next == '0) || hop_cut);
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ptr_q  <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            out_ptr_q  <= out_ptr_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_ptr  = out_ptr_q;
    assign out_vld  = out_vld_q;
    assign out_last = out_last_q;

endmodule

// File: tb/tb_ll_walker.sv
// Self-checking bench for ll_walker: a reference table model generates the
// expected beat sequence of every accepted list into a scoreboard queue; a
// negedge monitor pops and compares each handshaked beat and checks stalls.
module tb_ll_walker;

    localparam int N       = 32;
    localparam int W       = $clog2(N);
    localparam int TB_HOPS = 4;

    typedef struct packed {
        logic [W-1:0] ptr;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [W-1:0] wr_addr;
    logic [W-1:0] wr_next;
    logic [W-1:0] start;
    logic         start_vld;
    logic         start_rdy;
    logic [W-1:0] out_ptr;
    logic         out_vld;
    logic         out_rdy;
    logic         out_last;
    logic         err_loop;

    ll_walker #(.N(N), .W_PTR(W), .MAX_HOPS(TB_HOPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_next   (wr_next),
        .start     (start),
        .start_vld (start_vld),
        .start_rdy (start_rdy),
        .out_ptr   (out_ptr),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_last  (out_last),
        .err_loop  (err_loop)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    model [N];
    beat_t sb [$];
    int    beat_cyc [$];
    logic  mon_en    = 1'b1;
    logic  was_stall = 1'b0;
    logic [W-1:0] stall_ptr;
    logic         stall_last;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: stall hold, start_rdy during stall, scoreboard compare.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n || !mon_en) begin
            was_stall = 1'b0;
        end else begin
            if (was_stall) begin
                check("hold_vld", out_vld, 1);
                check("hold_ptr", out_ptr, stall_ptr);
                check("hold_last", out_last, stall_last);
            end
            if (out_vld && !out_rdy) begin
                check("stall_start_rdy", start_rdy, 0);
                was_stall  = 1'b1;
                stall_ptr  = out_ptr;
                stall_last = out_last;
            end else begin
                was_stall = 1'b0;
            end
            if (out_vld && out_rdy) begin
                beat_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_beat", out_ptr, 0);
                end else begin
                    e = sb.pop_front();
                    check("beat_ptr", out_ptr, e.ptr);
                    check("beat_last", out_last, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input int a, input int v);
        wr_en   = 1'b1;
        wr_addr = W'(a);
        wr_next = W'(v);
        step();
        wr_en = 1'b0;
        if (a != 0) model[a] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) model[i] = 0;
    endtask

    // Expected beats of the list starting at head, from the reference table.
    task automatic expect_list(input int head);
        beat_t e;
        int    p;
        int    hops;
        p    = head;
        hops = 0;
        while (p != 0 && hops < 200) begin
            hops++;
            e.ptr  = W'(p);
            e.last = (model[p] == 0);
`ifdef LL_HOP_LIMIT_EN
            if (hops == TB_HOPS && model[p] != 0) begin
                e.last = 1'b1;
                sb.push_back(e);
                break;
            end
`endif
            sb.push_back(e);
            p = model[p];
        end
    endtask

    task automatic offer_start(input int s);
        logic ok;
        start     = W'(s);
        start_vld = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("start_accept", ok, 1);
        step();
        start_vld = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        step();
        step();
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        beat_t e;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_next   = '0;
        start     = '0;
        start_vld = 1'b0;
        out_rdy   = 1'b1;
        model_clear();

        // Reset state.
        #22;
        check("rst_out_vld", out_vld, 0);
        check("rst_out_ptr", out_ptr, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err_loop", err_loop, 0);
        check("rst_start_rdy", start_rdy, 1);
        step();
        rst_n = 1'b1;
        step();

        // Two lists chained back to back: 7,15,8 | 1,5,3,10.
        tbl_write(1, 5);
        tbl_write(5, 3);
        tbl_write(3, 10);
        tbl_write(7, 15);
        tbl_write(15, 8);
        expect_list(7);
        expect_list(1);
        beat_cyc.delete();
        offer_start(7);
        offer_start(1);
        wait_drain();
        check("chain_beats", beat_cyc.size(), 7);
        if (beat_cyc.size() == 7) check("chain_gapless", beat_cyc[6] - beat_cyc[0], 6);

        // Backpressure with out_rdy pattern 1,0,0,1.
        expect_list(1);
        fork
            offer_start(1);
            begin
                for (int i = 0; i < 24; i++) begin
                    out_rdy = (i % 4 == 0) || (i % 4 == 3);
                    step();
                end
            end
        join
        out_rdy = 1'b1;
        wait_drain();

        // Empty list (start 0) then single-node list 6.
        offer_start(0);
        check("empty_list_no_out", out_vld, 0);
        expect_list(6);
        offer_start(6);
        wait_drain();

        // Write next[5]=0 on the edge that loads head 1: list becomes 1,5(last).
        e.ptr = W'(1); e.last = 1'b0; sb.push_back(e);
        e.ptr = W'(5); e.last = 1'b1; sb.push_back(e);
        check("idle_start_rdy", start_rdy, 1);
        start = W'(1); start_vld = 1'b1;
        wr_en = 1'b1; wr_addr = W'(5); wr_next = '0;
        step();
        start_vld = 1'b0; wr_en = 1'b0; model[5] = 0;
        wait_drain();

        // Write next[1]=0 on the edge that loads head 1: out_last uses the old value.
        e.ptr = W'(1); e.last = 1'b0; sb.push_back(e);
        start = W'(1); start_vld = 1'b1;
        wr_en = 1'b1; wr_addr = W'(1); wr_next = '0;
        step();
        start_vld = 1'b0; wr_en = 1'b0; model[1] = 0;
        wait_drain();

        // Reset mid-walk at node 11 of 9,14,11,13,12.
        tbl_write(9, 14);
        tbl_write(14, 11);
        tbl_write(11, 13);
        tbl_write(13, 12);
        expect_list(9);
        offer_start(9);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_vld && out_ptr == W'(11)) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_node_11", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_vld", out_vld, 0);
        check("async_rst_out_ptr", out_ptr, 0);
        check("async_rst_out_last", out_last, 0);
        sb.delete();
        model_clear();
        step();
        rst_n = 1'b1;
        step();
        expect_list(9);
        offer_start(9);
        wait_drain();
        check("post_rst_err_loop", err_loop, 0);

        // 4-node acyclic list: ends normally.
        tbl_write(20, 21);
        tbl_write(21, 22);
        tbl_write(22, 23);
        expect_list(20);
        offer_start(20);
        wait_drain();
        check("acyclic4_err_loop", err_loop, 0);

        // Cyclic list 2->4->2.
        tbl_write(2, 4);
        tbl_write(4, 2);
`ifdef LL_HOP_LIMIT_EN
        expect_list(2);
        offer_start(2);
        wait_drain();
        check("loop_err_set", err_loop, 1);
        check("loop_walk_stopped", out_vld, 0);
        repeat (5) step();
        check("loop_err_sticky", err_loop, 1);
        check("loop_start_rdy", start_rdy, 1);
`else
        mon_en = 1'b0;
        offer_start(2);
        repeat (20) step();
        check("loop_still_walking", out_vld, 1);
        check("loop_err_tied", err_loop, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_clear();
        step();
        mon_en = 1'b1;
        check("loop_rst_out_vld", out_vld, 0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
